// File: rtl/code_lock.sv
// code_lock: keypad code lock with one-hot button entry, press edge
// detection, entry timeout, failed-attempt counting and timed lockout.
// A complete entry is judged only after its last digit, so a wrong code
// never reveals which digit was wrong.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   i_code      reference code, digit 0 (first entered) in the top KW bits
//   i_key       debounced button levels, i_key[i] high means value i
//   o_unlocked  high while the door is open
//   o_lockout   high while further entries are refused
//   o_fail      one-cycle pulse on each wrong complete entry
//   o_entered   digits accepted in the current entry
//   o_fail_cnt  consecutive wrong entries
module code_lock #(
  parameter int KEYS           = 4,
  parameter int DIGITS         = 4,
  parameter int MAX_FAIL       = 3,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int OPEN_CYCLES    = 200,
  parameter int LOCK_CYCLES    = 1000,
  localparam int KW   = $clog2(KEYS),
  localparam int EW   = $clog2(DIGITS + 1),
  localparam int FW   = $clog2(MAX_FAIL + 1),
  localparam int TMAX = (TIMEOUT_CYCLES > OPEN_CYCLES)
                        ? ((TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES)
                        : ((OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES),
  localparam int TW   = $clog2(TMAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIGITS*KW-1:0] i_code,
  input  logic [KEYS-1:0]      i_key,
  output logic                 o_unlocked,
  output logic                 o_lockout,
  output logic                 o_fail,
  output logic [EW-1:0]        o_entered,
  output logic [FW-1:0]        o_fail_cnt
);

  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

  state_t               r_state, w_stateNext;
  logic [KEYS-1:0]      r_keyQ;
  logic [DIGITS*KW-1:0] r_codeQ, w_codeNext;
  logic [EW-1:0]        r_entered, w_enteredNext, w_count;
  logic [FW-1:0]        r_failCnt, w_failCntNext, w_failInc;
  logic [TW-1:0]        r_timer, w_timerNext;
  logic                 r_mismatch, w_mismatchNext;
  logic                 r_fail, w_failNext;

  logic                 w_press, w_oneHot, w_digitBad, w_entryBad;
  logic [KW-1:0]        w_keyVal, w_storedDigit, w_refDigit;

  // A press is a rising edge of "any key down"; rolling from one key to
  // another without a full release never registers.
  assign w_press  = (i_key != '0) && (r_keyQ == '0);
  assign w_oneHot = (i_key & (i_key - KEYS'(1))) == '0;

  // Index of the pressed key; only meaningful when exactly one bit is set.
  always_comb begin
    w_keyVal = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (i_key[i]) w_keyVal = KW'(i);
    end
  end

  // Stored digit selected by the number already entered.
  always_comb begin
    w_storedDigit = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (r_entered == EW'(j)) w_storedDigit = r_codeQ[(DIGITS-j)*KW-1 -: KW];
    end
  end

  // The first digit is compared against the live code because code_q is
  // only being captured on that same edge.
  assign w_refDigit = (r_state == IDLE) ? i_code[DIGITS*KW-1 -: KW] : w_storedDigit;
  assign w_digitBad = !w_oneHot || (w_keyVal != w_refDigit);
  assign w_entryBad = (r_state == IDLE) ? w_digitBad : (r_mismatch | w_digitBad);
  assign w_count    = (r_state == IDLE) ? EW'(1) : (r_entered + EW'(1));
  assign w_failInc  = r_failCnt + FW'(1);

  // Next-state and datapath logic for all four states.
  always_comb begin
    w_stateNext    = r_state;
    w_codeNext     = r_codeQ;
    w_enteredNext  = r_entered;
    w_failCntNext  = r_failCnt;
    w_timerNext    = r_timer;
    w_mismatchNext = r_mismatch;
    w_failNext     = 1'b0;
    case (r_state)
      IDLE, ENTRY: begin
        if (w_press) begin
          if (r_state == IDLE) w_codeNext = i_code;
          w_timerNext = '0;
          if (w_count == EW'(DIGITS)) begin
            w_enteredNext  = '0;
            w_mismatchNext = 1'b0;
            if (!w_entryBad) begin
              w_stateNext   = OPEN;
              w_failCntNext = '0;
            end else begin
              w_failNext    = 1'b1;
              w_failCntNext = w_failInc;
              w_stateNext   = (w_failInc == FW'(MAX_FAIL)) ? LOCKOUT : IDLE;
            end
          end else begin
            w_enteredNext  = w_count;
            w_mismatchNext = w_entryBad;
            w_stateNext    = ENTRY;
          end
        end else if (r_state == ENTRY) begin
          // Abandoned entry: discard progress silently, no failure counted.
          if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            w_stateNext    = IDLE;
            w_timerNext    = '0;
            w_enteredNext  = '0;
            w_mismatchNext = 1'b0;
          end else begin
            w_timerNext = r_timer + TW'(1);
          end
        end
      end
      OPEN: begin
        if (r_timer == TW'(OPEN_CYCLES - 1)) begin
          w_stateNext = IDLE;
          w_timerNext = '0;
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end
      LOCKOUT: begin
        if (r_timer == TW'(LOCK_CYCLES - 1)) begin
          w_stateNext   = IDLE;
          w_timerNext   = '0;
          w_failCntNext = '0;
        end else begin
          w_timerNext = r_timer + TW'(1);
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_keyQ     <= '0;
      r_codeQ    <= '0;
      r_entered  <= '0;
      r_failCnt  <= '0;
      r_timer    <= '0;
      r_mismatch <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_keyQ     <= i_key;
      r_codeQ    <= w_codeNext;
      r_entered  <= w_enteredNext;
      r_failCnt  <= w_failCntNext;
      r_timer    <= w_timerNext;
      r_mismatch <= w_mismatchNext;
      r_fail     <= w_failNext;
    end
  end

  assign o_unlocked = (r_state == OPEN);
  assign o_lockout  = (r_state == LOCKOUT);
  assign o_fail     = r_fail;
  assign o_entered  = r_entered;
  assign o_fail_cnt = r_failCnt;

endmodule

// File: tb/tb_code_lock.sv
// tb_code_lock: scoreboard bench for code_lock with default parameters.
// The stimulus pushes every expected output snapshot, together with how
// long the previous snapshot must have lasted, into a queue; the monitor
// pops one entry each time the DUT outputs change.
module tb_code_lock;

  typedef struct {
    logic unl;
    logic lck;
    logic fl;
    int   ent;
    int   fc;
    int   dwell;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_code;
  logic [3:0] i_key;
  logic       o_unlocked, o_lockout, o_fail;
  logic [2:0] o_entered;
  logic [1:0] o_fail_cnt;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   monOn       = 1'b0;
  logic [7:0] prevSnap = 8'hFF;
  logic [7:0] curSnap;
  int   dwellCnt    = 0;

  localparam logic [7:0] CODE = 8'b00_01_10_11;

  code_lock dut (
    .clk        (clk),
    .rst        (rst),
    .i_code     (i_code),
    .i_key      (i_key),
    .o_unlocked (o_unlocked),
    .o_lockout  (o_lockout),
    .o_fail     (o_fail),
    .o_entered  (o_entered),
    .o_fail_cnt (o_fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input logic unl, input logic lck, input logic fl,
                         input int ent, input int fc, input int dwell);
    exp_t e;
    e.unl = unl; e.lck = lck; e.fl = fl; e.ent = ent; e.fc = fc; e.dwell = dwell;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input int hold, input int gap);
    i_key = k;
    waitCycles(hold);
    i_key = '0;
    waitCycles(gap);
  endtask

  task automatic enterCode(input logic [3:0] k0, input logic [3:0] k1,
                           input logic [3:0] k2, input logic [3:0] k3);
    applyStimulus(k0, 3, 2);
    applyStimulus(k1, 3, 2);
    applyStimulus(k2, 3, 2);
    applyStimulus(k3, 3, 2);
  endtask

  // Pushes the snapshots of one 4-digit entry ending in a failure.
  task automatic expectWrong(input int fcBefore);
    pushExp(0, 0, 0, 1, fcBefore, 0);
    pushExp(0, 0, 0, 2, fcBefore, 5);
    pushExp(0, 0, 0, 3, fcBefore, 5);
    pushExp(0, (fcBefore + 1 == 3), 1, 0, fcBefore + 1, 5);
    pushExp(0, (fcBefore + 1 == 3), 0, 0, fcBefore + 1, 1);
  endtask

  // Pushes the snapshots of one correct entry including the full open window.
  task automatic expectOpen(input int fcBefore, input bit fullWindow);
    pushExp(0, 0, 0, 1, fcBefore, 0);
    pushExp(0, 0, 0, 2, fcBefore, 5);
    pushExp(0, 0, 0, 3, fcBefore, 5);
    pushExp(1, 0, 0, 0, 0, 5);
    if (fullWindow) pushExp(0, 0, 0, 0, 0, 200);
  endtask

  task automatic checkOutput(input int dwell);
    exp_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected-change: got unl=%0b lck=%0b fail=%0b ent=%0d fcnt=%0d, required no change",
               o_unlocked, o_lockout, o_fail, o_entered, o_fail_cnt);
    end else begin
      e = expQ.pop_front();
      if (o_unlocked !== e.unl || o_lockout !== e.lck || o_fail !== e.fl ||
          o_entered !== 3'(e.ent) || o_fail_cnt !== 2'(e.fc) ||
          (e.dwell != 0 && dwell != e.dwell)) begin
        miscompares++;
        $display("[TB] FAIL snapshot@%0t: got unl=%0b lck=%0b fail=%0b ent=%0d fcnt=%0d prev-dwell=%0d, required unl=%0b lck=%0b fail=%0b ent=%0d fcnt=%0d prev-dwell=%0d",
                 $time, o_unlocked, o_lockout, o_fail, o_entered, o_fail_cnt, dwell,
                 e.unl, e.lck, e.fl, e.ent, e.fc, e.dwell);
      end
    end
  endtask

  task automatic checkResetNow(input string tag);
    vectors++;
    if (o_unlocked !== 1'b0 || o_lockout !== 1'b0 || o_fail !== 1'b0 ||
        o_entered !== 3'd0 || o_fail_cnt !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL %s: got unl=%0b lck=%0b fail=%0b ent=%0d fcnt=%0d, required all zero",
               tag, o_unlocked, o_lockout, o_fail, o_entered, o_fail_cnt);
    end
  endtask

  // Monitor: compare against the scoreboard on every output change.
  always @(negedge clk) begin
    if (monOn) begin
      curSnap = {o_unlocked, o_lockout, o_fail, o_entered, o_fail_cnt};
      if (curSnap !== prevSnap) begin
        checkOutput(dwellCnt);
        prevSnap = curSnap;
        dwellCnt = 1;
      end else begin
        dwellCnt++;
      end
    end
  end

  initial begin
    rst    = 1'b1;
    i_key  = '0;
    i_code = CODE;
    pushExp(0, 0, 0, 0, 0, 0);
    waitCycles(3);
    monOn = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(3);

    $display("[TB] correct entry, presses ignored while open");
    expectOpen(0, 1'b1);
    enterCode(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    applyStimulus(4'b0001, 3, 2);
    applyStimulus(4'b0001, 3, 2);
    applyStimulus(4'b1000, 3, 2);
    waitCycles(200);

    $display("[TB] three wrong entries, lockout, presses ignored");
    for (int a = 0; a < 3; a++) begin
      expectWrong(a);
      enterCode(4'b0001, 4'b0010, 4'b0100, 4'b0100);
    end
    pushExp(0, 0, 0, 0, 0, 999);
    applyStimulus(4'b0001, 3, 2);
    applyStimulus(4'b0010, 3, 2);
    applyStimulus(4'b0100, 3, 2);
    waitCycles(1000);
    expectOpen(0, 1'b1);
    enterCode(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    waitCycles(200);

    $display("[TB] timeout keeps fail count");
    expectWrong(0);
    enterCode(4'b0001, 4'b0010, 4'b0100, 4'b0100);
    pushExp(0, 0, 0, 1, 1, 0);
    pushExp(0, 0, 0, 2, 1, 5);
    pushExp(0, 0, 0, 0, 1, 500);
    applyStimulus(4'b0001, 3, 2);
    applyStimulus(4'b0010, 3, 2);
    waitCycles(500);
    expectOpen(1, 1'b1);
    enterCode(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    waitCycles(200);

    $display("[TB] multi-key digit and held key");
    expectWrong(0);
    enterCode(4'b0001, 4'b0010, 4'b0011, 4'b1000);
    pushExp(0, 0, 0, 1, 1, 0);
    pushExp(0, 0, 0, 2, 1, 52);
    pushExp(0, 0, 0, 3, 1, 5);
    pushExp(1, 0, 0, 0, 0, 5);
    pushExp(0, 0, 0, 0, 0, 200);
    applyStimulus(4'b0001, 50, 2);
    applyStimulus(4'b0010, 3, 2);
    applyStimulus(4'b0100, 3, 2);
    applyStimulus(4'b1000, 3, 2);
    waitCycles(200);

    $display("[TB] reset mid-entry and mid-open");
    pushExp(0, 0, 0, 1, 0, 0);
    pushExp(0, 0, 0, 2, 0, 5);
    pushExp(0, 0, 0, 3, 0, 5);
    pushExp(0, 0, 0, 0, 0, 0);
    applyStimulus(4'b0001, 3, 2);
    applyStimulus(4'b0010, 3, 2);
    applyStimulus(4'b0100, 3, 2);
    rst = 1'b1;
    #1;
    checkResetNow("reset-in-entry");
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    expectOpen(0, 1'b0);
    pushExp(0, 0, 0, 0, 0, 0);
    applyStimulus(4'b0001, 3, 2);
    i_code = 8'b11_10_01_00;
    applyStimulus(4'b0010, 3, 2);
    applyStimulus(4'b0100, 3, 2);
    applyStimulus(4'b1000, 3, 2);
    waitCycles(20);
    rst = 1'b1;
    #1;
    checkResetNow("reset-in-open");
    waitCycles(2);
    rst = 1'b0;
    i_code = CODE;
    waitCycles(2);
    expectOpen(0, 1'b1);
    enterCode(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    waitCycles(205);

    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pending-expectations: got %0d unconsumed, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
